// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data memory between the cpu
// load/store path and a debug/loader port; cpu has priority.
module dmem_arbiter #(
  parameter int unsigned MAX_WAIT = 4,
  parameter int unsigned WCW      = 8
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [31:0] cpu_rdata,

  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic [31:0] dbg_addr,
  input  logic [31:0] dbg_wdata,
  input  logic        dbg_lock,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [31:0] dbg_rdata,

  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic {
    S_CPU,
    S_DBG
  } state_e;

  localparam logic [WCW-1:0] WMAX = WCW'(MAX_WAIT);

  state_e         state_q;
  logic [WCW-1:0] wait_q;
  logic [WCW-1:0] wait_d;
  logic           rd_pend_q;
  logic           rd_dbg_q;

  logic           cpu_win;
  logic           dbg_win;
  logic           any_rd;

  // Grants are suppressed entirely while reset is held.
  always_comb begin
    cpu_win = 1'b0;
    dbg_win = 1'b0;
    if (rst_n) begin
      unique case (state_q)
        S_CPU: begin
          dbg_win = dbg_req &&
                    (!cpu_req || wait_q == WMAX);
          cpu_win = cpu_req && !dbg_win;
        end
        S_DBG: begin
          dbg_win = dbg_req;
        end
        default: begin
          cpu_win = 1'b0;
          dbg_win = 1'b0;
        end
      endcase
    end
  end

  assign cpu_stall = rst_n && cpu_req && !cpu_win;
  assign dbg_gnt   = dbg_win;

  always_comb begin
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      dbg_win: begin
        mem_read  = !dbg_we;
        mem_write = dbg_we;
        mem_addr  = dbg_addr;
        mem_wdata = dbg_wdata;
      end
      cpu_win: begin
        mem_read  = !cpu_we;
        mem_write = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
      end
      default: begin
        mem_read  = 1'b0;
        mem_write = 1'b0;
      end
    endcase
  end

  assign any_rd = mem_read;

  // Refusal counter saturates so a forced grant stays armed.
  always_comb begin
    wait_d = '0;
    if (dbg_req && !dbg_win) begin
      if (wait_q == WMAX) begin
        wait_d = wait_q;
      end else begin
        wait_d = wait_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_CPU;
      wait_q    <= '0;
      rd_pend_q <= 1'b0;
      rd_dbg_q  <= 1'b0;
    end else begin
      wait_q    <= wait_d;
      rd_pend_q <= any_rd;
      rd_dbg_q  <= dbg_win;
      unique case (state_q)
        S_CPU: begin
          if (dbg_win && dbg_lock) begin
            state_q <= S_DBG;
          end
        end
        S_DBG: begin
          if (!dbg_lock) begin
            state_q <= S_CPU;
          end
        end
        default: begin
          state_q <= S_CPU;
        end
      endcase
    end
  end

  assign cpu_rvalid = rd_pend_q && !rd_dbg_q;
  assign dbg_rvalid = rd_pend_q && rd_dbg_q;
  assign cpu_rdata  = mem_rdata;
  assign dbg_rdata  = mem_rdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed stimulus, reference model compared every
// cycle, plus literal expectations for each scenario.
module tb_dmem_arbiter;
  localparam int MW = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_stall, cpu_rvalid;
  logic [31:0] cpu_rdata;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;
  logic        dbg_gnt, dbg_rvalid;
  logic [31:0] dbg_rdata;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;

  int total = 0;
  int bad = 0;
  bit go = 1'b0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MAX_WAIT(MW), .WCW(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid),
    .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we),
    .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_lock(dbg_lock), .dbg_gnt(dbg_gnt),
    .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_read(mem_read), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Synchronous single-port memory driven by the DUT pins.
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (mem_write) mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= mem_read ? mem[mem_addr[9:2]] : 32'h0;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: ownership mode, refusal count, pending read.
  logic [31:0] ref_mem [256];
  bit          burst_m = 0;
  bit          pend_m = 0;
  bit          own_dbg_m = 0;
  int          refd_m = 0;
  logic [31:0] pdata_m = '0;

  always @(negedge clk) begin
    bit          wd, wc, er, ew;
    logic [31:0] ea, ed;
    if (go) begin
      chk("m_cpu_rvalid", {31'b0, cpu_rvalid}, {31'b0, pend_m && !own_dbg_m});
      chk("m_dbg_rvalid", {31'b0, dbg_rvalid}, {31'b0, pend_m && own_dbg_m});
      if (pend_m && !own_dbg_m) chk("m_cpu_rdata", cpu_rdata, pdata_m);
      if (pend_m && own_dbg_m) chk("m_dbg_rdata", dbg_rdata, pdata_m);
      chk("m_wait_cnt", {24'b0, dut.wait_q}, refd_m);
      if (!rst_n) begin
        wd = 0;
        wc = 0;
      end else begin
        wd = dbg_req && (burst_m || !cpu_req || refd_m >= MW);
        wc = !burst_m && cpu_req && !wd;
      end
      er = (wd && !dbg_we) || (wc && !cpu_we);
      ew = (wd && dbg_we) || (wc && cpu_we);
      ea = wd ? dbg_addr : (wc ? cpu_addr : 32'h0);
      ed = wd ? dbg_wdata : (wc ? cpu_wdata : 32'h0);
      chk("m_dbg_gnt", {31'b0, dbg_gnt}, {31'b0, wd});
      chk("m_cpu_stall", {31'b0, cpu_stall},
          {31'b0, rst_n && cpu_req && !wc});
      chk("m_mem_read", {31'b0, mem_read}, {31'b0, er});
      chk("m_mem_write", {31'b0, mem_write}, {31'b0, ew});
      chk("m_mem_addr", mem_addr, ea);
      chk("m_mem_wdata", mem_wdata, ed);
      if (!rst_n) begin
        burst_m = 0;
        refd_m = 0;
        pend_m = 0;
      end else begin
        pend_m = er;
        own_dbg_m = wd;
        if (er) pdata_m = ref_mem[ea[9:2]];
        if (ew) ref_mem[ea[9:2]] = ed;
        burst_m = burst_m ? dbg_lock : (wd && dbg_lock);
        if (dbg_req && !wd) refd_m = (refd_m >= MW) ? MW : refd_m + 1;
        else refd_m = 0;
      end
    end
  end

  task automatic cyc(input bit rn,
                     input bit cr, input bit cw,
                     input logic [31:0] ca, input logic [31:0] cd,
                     input bit dr, input bit dw, input bit dl,
                     input logic [31:0] da, input logic [31:0] dd);
    @(posedge clk);
    #1;
    rst_n = rn;
    cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wdata = cd;
    dbg_req = dr; dbg_we = dw; dbg_lock = dl;
    dbg_addr = da; dbg_wdata = dd;
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    @(posedge clk);
    go = 1'b1;
    // reset with requests present
    cyc(0, 1, 0, 32'h10, 0, 1, 0, 0, 32'h14, 0);
    chk("rst_stall", {31'b0, cpu_stall}, 0);
    chk("rst_gnt", {31'b0, dbg_gnt}, 0);
    chk("rst_mrd", {31'b0, mem_read}, 0);
    chk("rst_rv", {31'b0, cpu_rvalid}, 0);
    idle();
    chk("rst_wait", {24'b0, dut.wait_q}, 0);

    // cpu only
    cyc(1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    chk("c_wr", {31'b0, mem_write}, 1);
    chk("c_addr", mem_addr, 32'h10);
    chk("c_st0", {31'b0, cpu_stall}, 0);
    cyc(1, 1, 0, 32'h10, 0, 0, 0, 0, 0, 0);
    chk("c_rd", {31'b0, mem_read}, 1);
    chk("c_st1", {31'b0, cpu_stall}, 0);
    idle();
    chk("c_rv", {31'b0, cpu_rvalid}, 1);
    chk("c_rdata", cpu_rdata, 32'hDEADBEEF);

    // contention
    for (int k = 0; k < 6; k++) begin
      cyc(1, 1, 1, 32'h40 + 4 * k, k, 1, 1, 0, 32'h80, 32'hD0 + k);
      chk("k_wait", {24'b0, dut.wait_q}, (k <= 4) ? k : 0);
      chk("k_gnt", {31'b0, dbg_gnt}, {31'b0, k == 4});
      chk("k_stall", {31'b0, cpu_stall}, {31'b0, k == 4});
    end
    idle();

    // read routing
    cyc(1, 1, 1, 32'h20, 32'h11112222, 1, 0, 0, 32'h24, 0);
    cyc(1, 1, 1, 32'h24, 32'h33334444, 1, 0, 0, 32'h24, 0);
    cyc(1, 1, 1, 32'h28, 32'h55556666, 1, 0, 0, 32'h24, 0);
    cyc(1, 1, 0, 32'h20, 0, 1, 0, 0, 32'h24, 0);
    chk("r_st0", {31'b0, cpu_stall}, 0);
    cyc(1, 1, 0, 32'h20, 0, 1, 0, 0, 32'h24, 0);
    chk("r_gnt", {31'b0, dbg_gnt}, 1);
    chk("r_st1", {31'b0, cpu_stall}, 1);
    chk("r_addr", mem_addr, 32'h24);
    chk("r_crv", {31'b0, cpu_rvalid}, 1);
    chk("r_cdata", cpu_rdata, 32'h11112222);
    chk("r_drv0", {31'b0, dbg_rvalid}, 0);
    idle();
    chk("r_drv", {31'b0, dbg_rvalid}, 1);
    chk("r_ddata", dbg_rdata, 32'h33334444);
    chk("r_crv0", {31'b0, cpu_rvalid}, 0);

    // burst lock
    cyc(1, 0, 0, 0, 0, 1, 1, 1, 32'h30, 32'hAAAA0001);
    chk("b_gnt0", {31'b0, dbg_gnt}, 1);
    cyc(1, 1, 0, 32'h20, 0, 1, 1, 1, 32'h34, 32'hAAAA0002);
    chk("b_st1", {31'b0, cpu_stall}, 1);
    cyc(1, 1, 0, 32'h20, 0, 0, 0, 1, 0, 0);
    chk("b_st2", {31'b0, cpu_stall}, 1);
    chk("b_idle", {30'b0, mem_read, mem_write}, 0);
    cyc(1, 1, 0, 32'h20, 0, 1, 1, 1, 32'h38, 32'hAAAA0003);
    chk("b_st3", {31'b0, cpu_stall}, 1);
    cyc(1, 1, 0, 32'h20, 0, 1, 0, 0, 32'h30, 0);
    chk("b_last", {31'b0, dbg_gnt}, 1);
    chk("b_st4", {31'b0, cpu_stall}, 1);
    cyc(1, 1, 0, 32'h20, 0, 0, 0, 0, 0, 0);
    chk("b_st5", {31'b0, cpu_stall}, 0);
    chk("b_drv", {31'b0, dbg_rvalid}, 1);
    chk("b_ddata", dbg_rdata, 32'hAAAA0001);
    idle();
    chk("b_cdata", cpu_rdata, 32'h11112222);

    // reset while in burst
    cyc(1, 0, 0, 0, 0, 1, 0, 1, 32'h34, 0);
    chk("x_gnt", {31'b0, dbg_gnt}, 1);
    cyc(0, 0, 0, 0, 0, 1, 0, 1, 32'h38, 0);
    chk("x_gnt_rst", {31'b0, dbg_gnt}, 0);
    chk("x_rd_rst", {31'b0, mem_read}, 0);
    chk("x_ddata", dbg_rdata, 32'hAAAA0002);
    cyc(1, 1, 0, 32'h28, 0, 1, 0, 1, 32'h38, 0);
    chk("x_st", {31'b0, cpu_stall}, 0);
    chk("x_gnt2", {31'b0, dbg_gnt}, 0);
    chk("x_rv", {30'b0, cpu_rvalid, dbg_rvalid}, 0);
    chk("x_wait", {24'b0, dut.wait_q}, 0);
    idle();
    chk("x_cdata", cpu_rdata, 32'h55556666);

    // idle
    for (int i = 0; i < 10; i++) begin
      idle();
      chk("i_mem", {30'b0, mem_read, mem_write}, 0);
      chk("i_rv", {30'b0, cpu_rvalid, dbg_rvalid}, 0);
      chk("i_wait", {24'b0, dut.wait_q}, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
